packet_filter_port_arbiter: RTL and testbench
=============================================

// Module: packet_filter_port_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that shares the single-lane filter pipeline
//  (header peek -> rules -> packet gate) between NUM_CMAC_PORT adapter RX streams.
//  Sits between the adapter RX ports and the filter's s_axis input, inside the 250 MHz box.
//  Grants one port per packet, holds the grant until that port's tlast beat is accepted,
//  then rotates priority. Keeps per-port packet counts.
// PARAMETERS
//  NUM_CMAC_PORT  1    number of requesting RX ports (1..4)
//  DATA_WIDTH     512  tdata width per port
//  KEEP_WIDTH     64   tkeep width per port (DATA_WIDTH/8)
// PORTS
//  axis_aclk          in   1                   250 MHz stream clock
//  box_rstn           in   1                   reset; asynchronous, active-low
//  s_axis_tvalid      in   NUM_CMAC_PORT       per-port valid
//  s_axis_tdata       in   DATA_WIDTH*N        per-port data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_axis_tkeep       in   KEEP_WIDTH*N        per-port keep
//  s_axis_tlast       in   NUM_CMAC_PORT       per-port last
//  s_axis_tuser_size  in   16*N                per-port packet size in bytes
//  s_axis_tuser_src   in   16*N                per-port source id
//  s_axis_tuser_dst   in   16*N                per-port destination id
//  s_axis_tready      out  NUM_CMAC_PORT       per-port ready
//  m_axis_tvalid      out  1                   merged stream to filter pipeline
//  m_axis_tdata       out  DATA_WIDTH          merged data
//  m_axis_tkeep       out  KEEP_WIDTH          merged keep
//  m_axis_tlast       out  1                   merged last
//  m_axis_tuser_size  out  16                  merged size
//  m_axis_tuser_src   out  16                  merged src
//  m_axis_tuser_dst   out  16                  merged dst
//  m_axis_tready      in   1                   ready from filter pipeline
//  grant_idx          out  $clog2(N) (min 1)   currently/last granted port
//  busy               out  1                   1 while a packet grant is held
//  cnt_pkt            out  32*N                per-port packets forwarded; wraps at 2^32
// BEHAVIOUR
//  Reset (box_rstn=0, async): state=IDLE, busy=0, grant_idx=0, last_grant=N-1,
//    cnt_pkt all 0, m_axis_tvalid=0, s_axis_tready all 0.
//    A reset mid-packet abandons the packet; the filter side sees no further beats of it.
//  State machine: IDLE, BUSY.
//   IDLE:
//    - m_axis_tvalid=0, s_axis_tready=0.
//    - If any s_axis_tvalid, select the first requester scanning last_grant+1,
//      last_grant+2, ... modulo N. Register it into grant_idx and go to BUSY
//      (one-cycle arbitration bubble).
//    - No requester: stay in IDLE.
//   BUSY (g = grant_idx):
//    - Datapath is a combinational mux with zero latency:
//      m_axis_tvalid = s_axis_tvalid[g]; m_axis_{tdata,tkeep,tlast,tuser_*} = port g fields.
//    - s_axis_tready[g] = m_axis_tready; every other s_axis_tready is 0.
//    - On a beat with s_axis_tvalid[g] & m_axis_tready & s_axis_tlast[g]:
//      last_grant <= g, cnt_pkt[g] += 1, go to IDLE.
//    - Other beats stay in BUSY. A tvalid gap on port g keeps the grant (no timeout).
//  Mux outputs while not BUSY: data/keep/tuser are don't-care; the bench must only check
//    them when m_axis_tvalid=1.
//  Grant never changes mid-packet, whatever the other ports' tvalid activity.
//  A single-beat packet (tlast on the first beat) occupies exactly one BUSY cycle when ready.
//  Throughput: one idle cycle per packet between consecutive grants.
//  N=1: degenerates to pass-through with the one-cycle bubble per packet; grant_idx stays 0.
//  Requester whose tvalid drops before grant (AXIS violation): not checked; grant still issued.
// TESTING
//  1. N=2; port0 sends a 3-beat pkt, m_tready=1 -> beats on m_axis at cycles 2,3,4 after tvalid;
//     cnt_pkt[0]=1, busy low after the tlast beat.
//  2. N=2; both ports hold 2-beat pkts continuously from reset -> grant order 0,1,0,1;
//     cnt_pkt={2,2} after 4 packets.
//  3. N=2; port0 mid-packet, port1 raises tvalid; m_tready toggles 1/0 -> port1 tready stays 0
//     until port0's tlast accepted; no beat duplicated or lost (scoreboard).
//  4. N=4; only port3 active, then only port1 -> each granted within 1 cycle of IDLE;
//     grant_idx=3, then 1.
//  5. box_rstn pulsed low for 1 cycle mid-packet on port1 -> all outputs at reset values
//     immediately; next grant goes to port0 if it requests.
//  6. Per-port counter preloaded near wrap (force 32'hFFFF_FFFF) + one pkt -> cnt reads 0;
//     other counters unaffected.

Source files
------------

// File: rtl/packet_filter_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : packet_filter_port_arbiter
// Brief    : Packet-granular round-robin arbiter that merges NUM_CMAC_PORT
//            AXI-Stream RX ports onto the single-lane filter pipeline input.
//            One port is granted per packet; the grant is held until that
//            port's tlast beat is accepted, then priority rotates.
//            Per-port forwarded-packet counters are kept.
// Revision : 1.0 - initial release
// ============================================================================
module packet_filter_port_arbiter #(
    parameter int NUM_CMAC_PORT = 1,
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = 64,
    localparam int c_IDX_W      = (NUM_CMAC_PORT > 1) ? $clog2(NUM_CMAC_PORT) : 1
) (
    input  logic                              axis_aclk,
    input  logic                              box_rstn,

    input  logic [NUM_CMAC_PORT-1:0]          s_axis_tvalid,
    input  logic [DATA_WIDTH*NUM_CMAC_PORT-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH*NUM_CMAC_PORT-1:0] s_axis_tkeep,
    input  logic [NUM_CMAC_PORT-1:0]          s_axis_tlast,
    input  logic [16*NUM_CMAC_PORT-1:0]       s_axis_tuser_size,
    input  logic [16*NUM_CMAC_PORT-1:0]       s_axis_tuser_src,
    input  logic [16*NUM_CMAC_PORT-1:0]       s_axis_tuser_dst,
    output logic [NUM_CMAC_PORT-1:0]          s_axis_tready,

    output logic                              m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic [15:0]                       m_axis_tuser_size,
    output logic [15:0]                       m_axis_tuser_src,
    output logic [15:0]                       m_axis_tuser_dst,
    input  logic                              m_axis_tready,

    output logic [c_IDX_W-1:0]                grant_idx,
    output logic                              busy,
    output logic [32*NUM_CMAC_PORT-1:0]       cnt_pkt
);

    // Slot table is padded to a power of two so the grant index addresses it
    // with an exactly matching width; padding slots never request.
    localparam int c_NUM_SLOT = 1 << c_IDX_W;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;
    logic [c_IDX_W-1:0]        r_grant_idx;
    logic [c_IDX_W-1:0]        r_last_grant;
    logic [32*NUM_CMAC_PORT-1:0] r_cnt_pkt;

    logic [c_NUM_SLOT-1:0]     w_slot_valid;
    logic [c_NUM_SLOT-1:0]     w_slot_last;
    logic [DATA_WIDTH-1:0]     w_slot_data [c_NUM_SLOT];
    logic [KEEP_WIDTH-1:0]     w_slot_keep [c_NUM_SLOT];
    logic [15:0]               w_slot_size [c_NUM_SLOT];
    logic [15:0]               w_slot_src  [c_NUM_SLOT];
    logic [15:0]               w_slot_dst  [c_NUM_SLOT];

    int                        w_base;
    logic [2*NUM_CMAC_PORT-1:0] w_req_dbl;
    logic [2*NUM_CMAC_PORT-1:0] w_req_shift;
    logic [NUM_CMAC_PORT-1:0]  w_req_rot;
    logic                      w_any_req;
    logic [c_IDX_W-1:0]        w_sel_idx;
    logic                      w_done;

    // Unpack the flat per-port buses into indexable slots
    for (genvar i = 0; i < c_NUM_SLOT; i++) begin : g_slot
        if (i < NUM_CMAC_PORT) begin : g_port
            assign w_slot_valid[i] = s_axis_tvalid[i];
            assign w_slot_last[i]  = s_axis_tlast[i];
            assign w_slot_data[i]  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign w_slot_keep[i]  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            assign w_slot_size[i]  = s_axis_tuser_size[i*16 +: 16];
            assign w_slot_src[i]   = s_axis_tuser_src[i*16 +: 16];
            assign w_slot_dst[i]   = s_axis_tuser_dst[i*16 +: 16];
        end else begin : g_pad
            assign w_slot_valid[i] = 1'b0;
            assign w_slot_last[i]  = 1'b0;
            assign w_slot_data[i]  = '0;
            assign w_slot_keep[i]  = '0;
            assign w_slot_size[i]  = '0;
            assign w_slot_src[i]   = '0;
            assign w_slot_dst[i]   = '0;
        end
    end

    // Round-robin pick: rotate requests so the port after last_grant is bit 0,
    // then take the lowest set bit
    always_comb begin
        w_base      = (int'(r_last_grant) + 1) % NUM_CMAC_PORT;
        w_req_dbl   = {s_axis_tvalid, s_axis_tvalid};
        w_req_shift = w_req_dbl >> w_base;
        w_req_rot   = w_req_shift[NUM_CMAC_PORT-1:0];
        w_any_req   = |w_req_rot;
        w_sel_idx   = '0;
        for (int k = NUM_CMAC_PORT - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_sel_idx = c_IDX_W'((w_base + k) % NUM_CMAC_PORT);
            end
        end
    end

    // Packet ends when the granted port's tlast beat is accepted downstream
    assign w_done = (r_state == c_ST_BUSY) && w_slot_valid[r_grant_idx]
                    && w_slot_last[r_grant_idx] && m_axis_tready;

    // State register
    always_ff @(posedge axis_aclk or negedge box_rstn) begin
        if (!box_rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE arbitrates for one cycle, BUSY holds until tlast accepted
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any_req) w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (w_done)    w_state_nxt = c_ST_IDLE;
            default:                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: valid/ready only pass through for the granted port while BUSY
    always_comb begin
        busy          = (r_state == c_ST_BUSY);
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (r_state == c_ST_BUSY) begin
            m_axis_tvalid = w_slot_valid[r_grant_idx];
            for (int i = 0; i < NUM_CMAC_PORT; i++) begin
                if (r_grant_idx == c_IDX_W'(i)) begin
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    // Grant and rotation pointer: grant latched on arbitration, pointer on tlast
    always_ff @(posedge axis_aclk or negedge box_rstn) begin
        if (!box_rstn) begin
            r_grant_idx  <= '0;
            r_last_grant <= c_IDX_W'(NUM_CMAC_PORT - 1);
        end else begin
            if ((r_state == c_ST_IDLE) && w_any_req) begin
                r_grant_idx <= w_sel_idx;
            end
            if (w_done) begin
                r_last_grant <= r_grant_idx;
            end
        end
    end

    // Per-port forwarded packet counters, free-running wrap at 2^32
    always_ff @(posedge axis_aclk or negedge box_rstn) begin
        if (!box_rstn) begin
            r_cnt_pkt <= '0;
        end else if (w_done) begin
            for (int i = 0; i < NUM_CMAC_PORT; i++) begin
                if (r_grant_idx == c_IDX_W'(i)) begin
                    r_cnt_pkt[i*32 +: 32] <= r_cnt_pkt[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    // Zero-latency payload mux from the granted port
    assign m_axis_tdata      = w_slot_data[r_grant_idx];
    assign m_axis_tkeep      = w_slot_keep[r_grant_idx];
    assign m_axis_tlast      = w_slot_last[r_grant_idx];
    assign m_axis_tuser_size = w_slot_size[r_grant_idx];
    assign m_axis_tuser_src  = w_slot_src[r_grant_idx];
    assign m_axis_tuser_dst  = w_slot_dst[r_grant_idx];

    assign grant_idx = r_grant_idx;
    assign cnt_pkt   = r_cnt_pkt;

endmodule
`default_nettype wire

// File: tb/tb_packet_filter_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_filter_port_arbiter
// Brief    : Directed bench for packet_filter_port_arbiter with a 2-port and a
//            4-port instance: vector table plus hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_filter_port_arbiter;

    localparam int DW = 32;
    localparam int KW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic box_rstn;

    // 2-port instance
    logic [1:0]  v2, l2, rdy2;
    logic [63:0] d2;
    logic [7:0]  k2;
    logic [31:0] sz2, src2, dst2;
    logic        mv2, ml2, mr2;
    logic [31:0] md2;
    logic [3:0]  mk2;
    logic [15:0] msz2, msrc2, mdst2;
    logic [0:0]  g2;
    logic        busy2;
    logic [63:0] cnt2;

    // 4-port instance
    logic [3:0]   v4, l4, rdy4;
    logic [127:0] d4;
    logic [15:0]  k4;
    logic [63:0]  sz4, src4, dst4;
    logic         mv4, ml4, mr4;
    logic [31:0]  md4;
    logic [3:0]   mk4;
    logic [15:0]  msz4, msrc4, mdst4;
    logic [1:0]   g4;
    logic         busy4;
    logic [127:0] cnt4;

    packet_filter_port_arbiter #(.NUM_CMAC_PORT(2), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut2 (
        .axis_aclk(clk), .box_rstn(box_rstn),
        .s_axis_tvalid(v2), .s_axis_tdata(d2), .s_axis_tkeep(k2), .s_axis_tlast(l2),
        .s_axis_tuser_size(sz2), .s_axis_tuser_src(src2), .s_axis_tuser_dst(dst2),
        .s_axis_tready(rdy2),
        .m_axis_tvalid(mv2), .m_axis_tdata(md2), .m_axis_tkeep(mk2), .m_axis_tlast(ml2),
        .m_axis_tuser_size(msz2), .m_axis_tuser_src(msrc2), .m_axis_tuser_dst(mdst2),
        .m_axis_tready(mr2),
        .grant_idx(g2), .busy(busy2), .cnt_pkt(cnt2)
    );

    packet_filter_port_arbiter #(.NUM_CMAC_PORT(4), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut4 (
        .axis_aclk(clk), .box_rstn(box_rstn),
        .s_axis_tvalid(v4), .s_axis_tdata(d4), .s_axis_tkeep(k4), .s_axis_tlast(l4),
        .s_axis_tuser_size(sz4), .s_axis_tuser_src(src4), .s_axis_tuser_dst(dst4),
        .s_axis_tready(rdy4),
        .m_axis_tvalid(mv4), .m_axis_tdata(md4), .m_axis_tkeep(mk4), .m_axis_tlast(ml4),
        .m_axis_tuser_size(msz4), .m_axis_tuser_src(msrc4), .m_axis_tuser_dst(mdst4),
        .m_axis_tready(mr4),
        .grant_idx(g4), .busy(busy4), .cnt_pkt(cnt4)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] pdata(input int p, input int b);
        return {4'hD, 4'(p), 16'h0000, 8'(b)};
    endfunction

    function automatic logic [3:0] pkeep(input int p);
        logic [3:0] f;
        f = 4'hF;
        return f >> p;
    endfunction

    function automatic logic [15:0] psize(input int p); return 16'h0040 + 16'(p); endfunction
    function automatic logic [15:0] psrc(input int p);  return 16'h5A00 + 16'(p); endfunction
    function automatic logic [15:0] pdst(input int p);  return 16'hC300 + 16'(p); endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] vld;
        logic [1:0] lst;
        int         b0;
        int         b1;
        logic       mrdy;
        logic       e_mvld;
        int         e_port;
        int         e_beat;
        logic       e_mlast;
        logic [1:0] e_srdy;
        logic       e_busy;
        logic       e_gnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [1:0] vld, input logic [1:0] lst, input int b0,
                                input int b1, input logic mrdy, input logic e_mvld,
                                input int e_port, input int e_beat, input logic e_mlast,
                                input logic [1:0] e_srdy, input logic e_busy, input logic e_gnt);
        vec_t v;
        v.vld = vld; v.lst = lst; v.b0 = b0; v.b1 = b1; v.mrdy = mrdy;
        v.e_mvld = e_mvld; v.e_port = e_port; v.e_beat = e_beat; v.e_mlast = e_mlast;
        v.e_srdy = e_srdy; v.e_busy = e_busy; v.e_gnt = e_gnt;
        return v;
    endfunction

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            v2  = vq[i].vld;
            l2  = vq[i].lst;
            d2  = {pdata(1, vq[i].b1), pdata(0, vq[i].b0)};
            mr2 = vq[i].mrdy;
            #1;
            chk($sformatf("%s[%0d].busy", tag, i), busy2, vq[i].e_busy);
            chk($sformatf("%s[%0d].grant", tag, i), g2, vq[i].e_gnt);
            chk($sformatf("%s[%0d].s_tready", tag, i), rdy2, vq[i].e_srdy);
            chk($sformatf("%s[%0d].m_tvalid", tag, i), mv2, vq[i].e_mvld);
            if (vq[i].e_mvld) begin
                chk($sformatf("%s[%0d].payload", tag, i),
                    {ml2, md2, mk2, msz2, msrc2, mdst2},
                    {vq[i].e_mlast, pdata(vq[i].e_port, vq[i].e_beat), pkeep(vq[i].e_port),
                     psize(vq[i].e_port), psrc(vq[i].e_port), pdst(vq[i].e_port)});
            end
        end
        vq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        v2 = '0; l2 = '0; mr2 = 1'b0;
        v4 = '0; mr4 = 1'b0;
        box_rstn = 1'b0;
        @(negedge clk);
        box_rstn = 1'b1;
    endtask

    logic [32:0] sb[$];
    logic [32:0] sb_exp;
    int b0s, b1s;

    initial begin
        box_rstn = 1'b0;
        v2 = '0; l2 = '0; d2 = '0; mr2 = 1'b0;
        k2   = {pkeep(1), pkeep(0)};
        sz2  = {psize(1), psize(0)};
        src2 = {psrc(1), psrc(0)};
        dst2 = {pdst(1), pdst(0)};
        v4 = '0; mr4 = 1'b0; l4 = 4'hF;
        d4   = {pdata(3, 0), pdata(2, 0), pdata(1, 0), pdata(0, 0)};
        k4   = {pkeep(3), pkeep(2), pkeep(1), pkeep(0)};
        sz4  = {psize(3), psize(2), psize(1), psize(0)};
        src4 = {psrc(3), psrc(2), psrc(1), psrc(0)};
        dst4 = {pdst(3), pdst(2), pdst(1), pdst(0)};

        // Reset state
        @(negedge clk);
        #1;
        chk("rst2", {busy2, mv2, rdy2, g2, cnt2}, '0);
        chk("rst4", {busy4, mv4, rdy4, g4, cnt4}, '0);
        @(negedge clk);
        box_rstn = 1'b1;

        // 3-beat packet on port0, with two backpressure cycles
        vq.push_back(mk(2'b01, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0));
        vq.push_back(mk(2'b01, 2'b00, 0, 0, 1'b1, 1'b1, 0, 0, 1'b0, 2'b01, 1'b1, 1'b0));
        vq.push_back(mk(2'b01, 2'b00, 1, 0, 1'b0, 1'b1, 0, 1, 1'b0, 2'b00, 1'b1, 1'b0));
        vq.push_back(mk(2'b01, 2'b00, 1, 0, 1'b1, 1'b1, 0, 1, 1'b0, 2'b01, 1'b1, 1'b0));
        vq.push_back(mk(2'b01, 2'b01, 2, 0, 1'b0, 1'b1, 0, 2, 1'b1, 2'b00, 1'b1, 1'b0));
        vq.push_back(mk(2'b01, 2'b01, 2, 0, 1'b1, 1'b1, 0, 2, 1'b1, 2'b01, 1'b1, 1'b0));
        vq.push_back(mk(2'b00, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0));
        run_vecs("t1");
        chk("t1_cnt", cnt2, {32'd0, 32'd1});

        // Both ports stream 2-beat packets: grants 0,1,0,1
        do_reset();
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0));
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b1, 0, 0, 1'b0, 2'b01, 1'b1, 1'b0));
        vq.push_back(mk(2'b11, 2'b01, 1, 0, 1'b1, 1'b1, 0, 1, 1'b1, 2'b01, 1'b1, 1'b0));
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0));
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b1, 1, 0, 1'b0, 2'b10, 1'b1, 1'b1));
        vq.push_back(mk(2'b11, 2'b10, 0, 1, 1'b1, 1'b1, 1, 1, 1'b1, 2'b10, 1'b1, 1'b1));
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b1));
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b1, 0, 0, 1'b0, 2'b01, 1'b1, 1'b0));
        vq.push_back(mk(2'b11, 2'b01, 1, 0, 1'b1, 1'b1, 0, 1, 1'b1, 2'b01, 1'b1, 1'b0));
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0));
        vq.push_back(mk(2'b11, 2'b00, 0, 0, 1'b1, 1'b1, 1, 0, 1'b0, 2'b10, 1'b1, 1'b1));
        vq.push_back(mk(2'b11, 2'b10, 0, 1, 1'b1, 1'b1, 1, 1, 1'b1, 2'b10, 1'b1, 1'b1));
        vq.push_back(mk(2'b00, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b1));
        run_vecs("t2");
        chk("t2_cnt", cnt2, {32'd2, 32'd2});

        // Port1 requests mid-packet of port0 while m_tready toggles
        do_reset();
        sb.delete();
        for (int b = 0; b < 4; b++) sb.push_back({(b == 3), pdata(0, b)});
        for (int b = 0; b < 2; b++) sb.push_back({(b == 1), pdata(1, b)});
        b0s = 0;
        b1s = 0;
        for (int cyc = 0; cyc < 40 && (b0s < 4 || b1s < 2); cyc++) begin
            @(negedge clk);
            v2  = {(cyc >= 3 && b1s < 2), (b0s < 4)};
            l2  = {(b1s == 1), (b0s == 3)};
            d2  = {pdata(1, b1s), pdata(0, b0s)};
            mr2 = (cyc % 2 == 0);
            #1;
            if (b0s < 4 && cyc >= 3) chk("t3_p1_blocked", rdy2[1], 1'b0);
            if (mv2 && mr2) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL t3_extra_beat: got %0h expected none", md2);
                end else begin
                    sb_exp = sb.pop_front();
                    chk("t3_beat", {ml2, md2}, sb_exp);
                end
            end
            if (v2[0] && rdy2[0]) b0s++;
            if (v2[1] && rdy2[1]) b1s++;
        end
        @(negedge clk);
        v2 = '0;
        chk("t3_p0_beats", b0s, 4);
        chk("t3_p1_beats", b1s, 2);
        chk("t3_sb_left", sb.size(), 0);
        chk("t3_cnt", cnt2, {32'd1, 32'd1});

        // 4-port rotation: port3 alone, port1 alone, then port0+port2
        @(negedge clk);
        v4 = 4'b1000; mr4 = 1'b1;
        #1 chk("t4_idle_a", {busy4, mv4, rdy4}, 6'b0);
        @(negedge clk);
        #1 chk("t4_gnt3", {busy4, g4, rdy4}, {1'b1, 2'd3, 4'b1000});
        chk("t4_pay3", {mv4, ml4, md4}, {2'b11, pdata(3, 0)});
        @(negedge clk);
        v4 = 4'b0010;
        #1 chk("t4_idle_b", {busy4, mv4, g4}, {2'b00, 2'd3});
        @(negedge clk);
        #1 chk("t4_gnt1", {busy4, g4, rdy4}, {1'b1, 2'd1, 4'b0010});
        chk("t4_pay1", {mv4, ml4, md4}, {2'b11, pdata(1, 0)});
        @(negedge clk);
        v4 = 4'b0101;
        #1 chk("t4_idle_c", busy4, 1'b0);
        @(negedge clk);
        #1 chk("t4_gnt2", {busy4, g4, rdy4}, {1'b1, 2'd2, 4'b0100});
        @(negedge clk);
        v4 = 4'b0001;
        #1 chk("t4_idle_d", busy4, 1'b0);
        @(negedge clk);
        #1 chk("t4_gnt0", {busy4, g4, rdy4}, {1'b1, 2'd0, 4'b0001});
        @(negedge clk);
        v4 = 4'b0000;
        #1 chk("t4_cnt", cnt4, {32'd1, 32'd1, 32'd1, 32'd1});

        // Asynchronous reset mid-packet on port1
        do_reset();
        @(negedge clk);
        v2 = 2'b10; l2 = 2'b00; d2 = {pdata(1, 0), pdata(0, 0)}; mr2 = 1'b1;
        @(negedge clk);
        #1 chk("t5_gnt1", {busy2, g2}, {1'b1, 1'b1});
        @(negedge clk);
        d2 = {pdata(1, 1), pdata(0, 0)};
        #1 chk("t5_beat1", {mv2, md2}, {1'b1, pdata(1, 1)});
        #1 box_rstn = 1'b0;
        #1 chk("t5_rst_now", {busy2, mv2, rdy2, g2, cnt2}, '0);
        v2 = 2'b11; l2 = 2'b01; d2 = {pdata(1, 0), pdata(0, 0)};
        @(negedge clk);
        box_rstn = 1'b1;
        @(negedge clk);
        #1 chk("t5_regrant", {busy2, g2, rdy2}, {1'b1, 1'b0, 2'b01});
        chk("t5_pay", {mv2, ml2, md2}, {2'b11, pdata(0, 0)});
        @(negedge clk);
        v2 = 2'b00;
        #1 chk("t5_cnt", cnt2, {32'd0, 32'd1});

        // Counter wrap on port0, port1 counter left alone
        @(negedge clk);
        force dut2.r_cnt_pkt = {32'd7, 32'hFFFF_FFFF};
        #1 release dut2.r_cnt_pkt;
        v2 = 2'b01; l2 = 2'b01; d2 = {pdata(1, 0), pdata(0, 0)}; mr2 = 1'b1;
        @(negedge clk);
        #1 chk("t6_busy", {busy2, g2}, {1'b1, 1'b0});
        @(negedge clk);
        v2 = 2'b00;
        #1 chk("t6_wrap", cnt2, {32'd7, 32'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
